// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types for the prefetching instruction fetch stage.
// Holds the fetch buffer entry layout and the reset NOP encoding.
package instr_fetch_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and clear.
// Clear and reset empty the queue; the storage array is left untouched.
module fetch_fifo
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  fetch_entry_t               i_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output fetch_entry_t               o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear && !rst)
      r_mem[r_wptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Prefetching fetch stage: sequential word fetch, FIFO buffering, redirect flush.
// Define IFB_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_drop;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_entry;
  logic [31:0]   w_redir_pc;
  int            w_live;
  logic          w_issue;
  logic          w_rsp;
  logic          w_keep;
  logic          w_discard;
  logic          w_fifo_valid;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;

  assign w_redir_pc = word_align(redirect_pc);
  assign w_entry    = '{pc: r_resp_pc, instr: mem_rdata};

  // Words already owed to the core: buffered plus live (non-dropped) requests.
  assign w_live = int'(w_count) + int'(r_inflight) - int'(r_drop);

  assign mem_req = !rst && !redirect
                && (int'(r_inflight) < MAX_OUTSTANDING)
                && (w_live < DEPTH);
  assign mem_addr = r_fetch_pc;

  assign w_issue   = mem_req && mem_gnt;
  assign w_rsp     = mem_rvalid && (r_inflight != '0);
  assign w_keep    = w_rsp && (r_drop == '0);
  assign w_discard = w_rsp && (r_drop != '0);

  assign w_fifo_valid = !rst && !redirect && (w_count != '0);

`ifdef IFB_BYPASS_EN
  assign w_byp = !rst && !redirect && w_keep && (w_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_push = w_keep && !redirect && !(w_byp && instr_ready);
  assign w_pop  = w_fifo_valid && instr_ready;

  always_comb begin
    instr_valid = w_fifo_valid;
    instruction = NOP_INSTR;
    pc          = r_resp_pc;
    if (w_count != '0) begin
      instruction = w_head.instr;
      pc          = w_head.pc;
    end
    if (w_byp) begin
      instr_valid = 1'b1;
      instruction = mem_rdata;
      pc          = r_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= r_inflight + IW'(w_issue) - IW'(w_rsp);
      if (redirect) begin
        // No issue happens in a redirect cycle, so every survivor is stale.
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_drop     <= r_inflight - IW'(w_rsp);
      end else begin
        if (w_issue)   r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_keep)    r_resp_pc  <= r_resp_pc + 32'd4;
        if (w_discard) r_drop     <= r_drop - IW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .i_data  (w_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rvalid && r_inflight == '0))
        else $error("ifb: response with nothing in flight");
      assert (r_drop <= r_inflight)
        else $error("ifb: drop exceeds inflight");
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: pipelined memory model plus stream scoreboard.
// Expected stream is target, target+4, ... with data from a hashed ROM.
module tb_instr_fetch_buffer;

  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h00000000;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef IFB_BYPASS_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          live = 0;
  int          rst_seen = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic        s_valid;
  logic        s_req;
  logic [31:0] s_pc;
  logic [31:0] s_addr;

  instr_fetch_buffer #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive memory response, sample/check outputs, advance model.
  task automatic step();
    logic [31:0] tgt;
    mem_rvalid = !rst && memq.size() != 0 && memq[0].due == cyc;
    mem_rdata  = mem_rvalid ? rom(memq[0].addr) : $urandom;
    #1;
    s_valid = instr_valid;
    s_req   = mem_req;
    s_pc    = pc;
    s_addr  = mem_addr;
    if (rst) begin
      if (rst_seen > 0) begin
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", pc, RST_PC);
      end
      rst_seen++;
      memq.delete();
      exp_pc    = RST_PC;
      exp_fetch = RST_PC;
      live      = 0;
    end else begin
      rst_seen = 0;
      if (mem_req) chk("addr", mem_addr, exp_fetch);
      if (redirect) begin
        chk("redir_req", mem_req, 0);
        chk("redir_valid", instr_valid, 0);
      end
      if (instr_valid) begin
        chk("pc", pc, exp_pc);
        chk("instr", instruction, rom(exp_pc));
        if (instr_ready) begin
          exp_pc = exp_pc + 32'd4;
          live--;
        end
      end
      if (mem_rvalid) void'(memq.pop_front());
      if (mem_req && mem_gnt) begin
        memq.push_back('{addr: mem_addr, due: cyc + lat});
        exp_fetch = exp_fetch + 32'd4;
        live++;
      end
      if (redirect) begin
        tgt       = {redirect_pc[31:2], 2'b00};
        exp_pc    = tgt;
        exp_fetch = tgt;
        live      = 0;
      end
      chk("credit", 32'(live <= DEPTH), 1);
      chk("outstanding", 32'(memq.size() <= MAXO), 1);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    mem_gnt     = 1'b0;
    repeat (3) step();
    rst     = 1'b0;
    mem_gnt = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] want);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = s_valid;
    end
    chk({tag, "_seen"}, found, 1);
    if (found) chk(tag, s_pc, want);
  endtask

  task automatic redir(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    logic reached;

    // Straight-line stream after reset, one word per cycle
    lat = 1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step();
      if (i < FIRST) chk("lat_early", s_valid, 0);
      else           chk("stream", s_valid, 1);
      if (i == FIRST) chk("first_pc", s_pc, RST_PC);
    end

    // Core stalls: buffer fills, requests stop, then drains in order
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    chk("sat_req", s_req, 0);
    chk("sat_live", live, DEPTH);
    instr_ready = 1'b1;
    repeat (12) step();
    chk("drained_pc", exp_pc >= 32'd16, 1);

    // Redirect with two requests in flight, L=2
    lat = 2;
    do_reset();
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      reached = (memq.size() == 2);
    end
    chk("two_inflight", reached, 1);
    redir(32'h40);
    wait_valid("redir40", 32'h40);
    repeat (6) step();

    // Misaligned redirect target
    lat = 1;
    do_reset();
    repeat (5) step();
    redir(32'h43);
    step();
    chk("r43_req", s_req, 1);
    chk("r43_addr", s_addr, 32'h40);
    wait_valid("r43", 32'h40);

    // Back-to-back redirects: last one wins
    repeat (5) step();
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    wait_valid("r100", 32'h100);
    repeat (4) step();

    // Random traffic with address wrap, redirects and resets
    lat = 3;
    do_reset();
    redir(32'hFFFFFFF8);
    for (int i = 0; i < 600; i++) begin
      mem_gnt     = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst      = 1'b0;
    redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
